// File: rtl/veri_bellegi_hakem.sv
// Round-robin arbiter and sequencer sharing one 2^ADRES_GENISLIK x 32 data memory between two requesters.
// Each request is accepted in BOSTA, gets one ERISIM cycle, then a registered one-cycle response.
`timescale 1ns/1ps
module veri_bellegi_hakem #(
    parameter int ADRES_GENISLIK    = 8,
    parameter bit BASLANGIC_ONCELIK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        istek0_gecerli,
    output logic        istek0_hazir,
    input  logic [31:0] istek0_adres,
    input  logic [31:0] istek0_veri,
    input  logic        istek0_yaz,
    input  logic [3:0]  istek0_maske,
    output logic        yanit0_gecerli,
    output logic [31:0] yanit0_veri,
    output logic        yanit0_hata,
    input  logic        istek1_gecerli,
    output logic        istek1_hazir,
    input  logic [31:0] istek1_adres,
    input  logic [31:0] istek1_veri,
    input  logic        istek1_yaz,
    input  logic [3:0]  istek1_maske,
    output logic        yanit1_gecerli,
    output logic [31:0] yanit1_veri,
    output logic        yanit1_hata,
    output logic [31:0] bel_adres,
    output logic [31:0] bel_veri_girisi,
    output logic        bel_yaz,
    input  logic [31:0] bel_veri_cikisi
);

    typedef enum logic {BOSTA, ERISIM} durum_t;

    typedef struct packed {
        logic [31:0] adres;
        logic [31:0] veri;
        logic        yaz;
        logic [3:0]  maske;
    } istek_t;

    durum_t            durum_q, durum_d;
    istek_t            istek_q, istek_d;
    logic              port_q, port_d;
    logic              oncelik_q, oncelik_d;
    logic [1:0]        yanit_gecerli_q, yanit_gecerli_d;
    logic [1:0]        yanit_hata_q, yanit_hata_d;
    logic [1:0][31:0]  yanit_veri_q, yanit_veri_d;

    istek_t     istek_p0, istek_p1, secilen_istek;
    logic [1:0] gecerli;
    logic       secilen, kabul, erisim, hata;
    logic [31:0] maske_bit;

    assign istek_p0      = {istek0_adres, istek0_veri, istek0_yaz, istek0_maske};
    assign istek_p1      = {istek1_adres, istek1_veri, istek1_yaz, istek1_maske};
    assign gecerli       = {istek1_gecerli, istek0_gecerli};
    assign secilen       = (&gecerli) ? oncelik_q : gecerli[1];
    assign secilen_istek = secilen ? istek_p1 : istek_p0;

    // Gating with rst_n keeps hazir low while reset is held, even though the state is already BOSTA.
    assign kabul        = rst_n && (durum_q == BOSTA) && (|gecerli);
    assign istek0_hazir = kabul && !secilen;
    assign istek1_hazir = kabul && secilen;

    assign erisim = (durum_q == ERISIM);
    assign hata   = (istek_q.adres[1:0] != 2'b00) ||
                    ((istek_q.adres >> (ADRES_GENISLIK + 2)) != '0);

    always_comb begin
        for (int i = 0; i < 4; i++) maske_bit[8*i +: 8] = {8{istek_q.maske[i]}};
    end

    // Memory-side outputs are only driven during the access cycle; idle/reset leaves them at zero.
    assign bel_adres       = erisim ? {{(32-ADRES_GENISLIK){1'b0}}, istek_q.adres[ADRES_GENISLIK+1:2]} : '0;
    assign bel_veri_girisi = erisim ? ((bel_veri_cikisi & ~maske_bit) | (istek_q.veri & maske_bit)) : '0;
    assign bel_yaz         = erisim && istek_q.yaz && !hata && (istek_q.maske != 4'b0000);

    always_comb begin
        durum_d         = durum_q;
        istek_d         = istek_q;
        port_d          = port_q;
        oncelik_d       = oncelik_q;
        yanit_gecerli_d = '0;
        yanit_hata_d    = '0;
        yanit_veri_d    = '0;
        case (durum_q)
            BOSTA: begin
                if (kabul) begin
                    durum_d   = ERISIM;
                    istek_d   = secilen_istek;
                    port_d    = secilen;
                    oncelik_d = ~secilen;
                end
            end
            ERISIM: begin
                durum_d                 = BOSTA;
                yanit_gecerli_d[port_q] = 1'b1;
                yanit_hata_d[port_q]    = hata;
                yanit_veri_d[port_q]    = (hata || istek_q.yaz) ? 32'h0 : bel_veri_cikisi;
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q         <= BOSTA;
            istek_q         <= '0;
            port_q          <= 1'b0;
            oncelik_q       <= BASLANGIC_ONCELIK;
            yanit_gecerli_q <= '0;
            yanit_hata_q    <= '0;
            yanit_veri_q    <= '0;
        end else begin
            durum_q         <= durum_d;
            istek_q         <= istek_d;
            port_q          <= port_d;
            oncelik_q       <= oncelik_d;
            yanit_gecerli_q <= yanit_gecerli_d;
            yanit_hata_q    <= yanit_hata_d;
            yanit_veri_q    <= yanit_veri_d;
        end
    end

    assign yanit0_gecerli = yanit_gecerli_q[0];
    assign yanit0_hata    = yanit_hata_q[0];
    assign yanit0_veri    = yanit_veri_q[0];
    assign yanit1_gecerli = yanit_gecerli_q[1];
    assign yanit1_hata    = yanit_hata_q[1];
    assign yanit1_veri    = yanit_veri_q[1];

endmodule
